// File: rtl/hazard_ctrl_pkg.sv
// hazard_ctrl_pkg
// Shared encodings for the pipeline hazard controller:
//   state_t : FSM state encoding (also driven out on the debug state port)
//   fwd_t   : operand forwarding select encoding
//   REG_PC  : register number of the PC, which is never forwarded or stalled on
package hazard_ctrl_pkg;

  typedef enum logic [1:0] {
    ST_HOLD     = 2'b00,
    ST_RUN      = 2'b01,
    ST_MEM_WAIT = 2'b10,
    ST_UNUSED   = 2'b11
  } state_t;

  typedef enum logic [1:0] {
    FWD_RF  = 2'b00,
    FWD_EX  = 2'b01,
    FWD_MEM = 2'b10,
    FWD_WB  = 2'b11
  } fwd_t;

  localparam logic [3:0] REG_PC = 4'd15;

endpackage

// File: rtl/hazard_ctrl_fwd_select.sv
// fwd_select
// Forwarding select for one ID-stage source operand. The youngest producer
// wins: EX, then MEM, then WB, otherwise the register file value is used.
// Ports:
//   src        : source register number
//   src_used   : source is actually read by the ID instruction
//   ex_rd      : EX destination,  ex_fwd_en  : EX result is forwardable (ALU write)
//   mem_rd     : MEM destination, mem_fwd_en : MEM stage writes the register file
//   wb_rd      : WB destination,  wb_fwd_en  : WB stage writes the register file
//   sel        : 2-bit select (FWD_RF / FWD_EX / FWD_MEM / FWD_WB)
module fwd_select
  import hazard_ctrl_pkg::*;
(
  input  logic [3:0] src,
  input  logic       src_used,
  input  logic [3:0] ex_rd,
  input  logic       ex_fwd_en,
  input  logic [3:0] mem_rd,
  input  logic       mem_fwd_en,
  input  logic [3:0] wb_rd,
  input  logic       wb_fwd_en,
  output logic [1:0] sel
);

  // R15 reads the PC path, so it never takes a forwarded value.
  always_comb begin
    sel = FWD_RF;
    if (src_used && (src != REG_PC)) begin
      if (ex_fwd_en && (ex_rd == src)) begin
        sel = FWD_EX;
      end else if (mem_fwd_en && (mem_rd == src)) begin
        sel = FWD_MEM;
      end else if (wb_fwd_en && (wb_rd == src)) begin
        sel = FWD_WB;
      end
    end
  end

endmodule

// File: rtl/hazard_ctrl.sv
// hazard_ctrl
// Pipeline sequencing and hazard controller for the 5-stage pipeline.
// Holds the pipe for a startup period after reset, inserts load-use bubbles,
// flushes IF_ID on taken branches, freezes the pipe while data memory waits,
// and produces operand forwarding selects for the ID stage.
// Optional feature macro: HAZARD_PERF_EN (adds saturating performance counters;
// when undefined the counter ports are tied to zero).
// Ports:
//   Clk, Reset                       : clock, synchronous active-high reset
//   id_rn/id_rm/id_rd, id_use_*      : ID source registers and their read flags
//   ex_rd/mem_rd/wb_rd, *_rf_e       : stage destinations and RF write enables
//   ex_mem_e                         : EX instruction is a load
//   branch_taken                     : ID branch resolved taken
//   mem_ready                        : data memory done (0 = wait)
//   pc_enable, if_id_enable          : fetch-side load enables
//   ctrl_nop                         : bubble into ID_EX
//   if_id_flush                      : IF_ID loads a NOP on the next edge
//   pipe_hold                        : freeze ID_EX, EX_MEM, MEM_WB
//   fwd_a/fwd_b/fwd_c                : Rn/Rm/Rd forwarding selects
//   mem_timeout                      : sticky memory-wait timeout flag
//   state                            : FSM state (debug)
//   stall_count/flush_count/wait_count : performance counters
module hazard_ctrl
  import hazard_ctrl_pkg::*;
#(
  parameter int unsigned STARTUP_CYCLES = 2,
  parameter int unsigned MEM_TIMEOUT    = 15
) (
  input  logic        Clk,
  input  logic        Reset,
  input  logic [3:0]  id_rn,
  input  logic [3:0]  id_rm,
  input  logic [3:0]  id_rd,
  input  logic        id_use_rn,
  input  logic        id_use_rm,
  input  logic        id_use_rd,
  input  logic [3:0]  ex_rd,
  input  logic [3:0]  mem_rd,
  input  logic [3:0]  wb_rd,
  input  logic        ex_rf_e,
  input  logic        mem_rf_e,
  input  logic        wb_rf_e,
  input  logic        ex_mem_e,
  input  logic        branch_taken,
  input  logic        mem_ready,
  output logic        pc_enable,
  output logic        if_id_enable,
  output logic        ctrl_nop,
  output logic        if_id_flush,
  output logic        pipe_hold,
  output logic [1:0]  fwd_a,
  output logic [1:0]  fwd_b,
  output logic [1:0]  fwd_c,
  output logic        mem_timeout,
  output logic [1:0]  state,
  output logic [15:0] stall_count,
  output logic [15:0] flush_count,
  output logic [15:0] wait_count
);

  localparam logic [3:0] STARTUP_INIT = 4'(STARTUP_CYCLES);
  localparam logic [7:0] TIMEOUT_VAL  = 8'(MEM_TIMEOUT);

  state_t     state_q, state_d;
  logic [3:0] cnt_q, cnt_d;
  logic [7:0] wait_cnt_q, wait_cnt_d;
  logic       timeout_q, timeout_d;

  logic       load_use;
  logic       fwd_active;
  logic       stall_evt;
  logic [1:0] raw_a, raw_b, raw_c;

  // A load in EX whose destination is read in ID cannot be forwarded yet;
  // one bubble lets it reach MEM where the value becomes forwardable.
  always_comb begin
    load_use = ex_mem_e && ex_rf_e && (ex_rd != REG_PC) &&
               ((id_use_rn && (id_rn == ex_rd)) ||
                (id_use_rm && (id_rm == ex_rd)) ||
                (id_use_rd && (id_rd == ex_rd)));
  end

  // Next-state and pipeline control. RUN and MEM_WAIT share one path: a
  // not-ready memory freezes the pipe, otherwise the normal hazard priority
  // (load-use, then branch flush, then free run) applies in the same cycle.
  always_comb begin
    state_d      = state_q;
    cnt_d        = cnt_q;
    wait_cnt_d   = wait_cnt_q;
    timeout_d    = timeout_q;
    pc_enable    = 1'b0;
    if_id_enable = 1'b0;
    ctrl_nop     = 1'b1;
    if_id_flush  = 1'b0;
    pipe_hold    = 1'b0;
    fwd_active   = 1'b0;
    stall_evt    = 1'b0;

    if (Reset) begin
      state_d    = ST_HOLD;
      cnt_d      = STARTUP_INIT;
      wait_cnt_d = '0;
      timeout_d  = 1'b0;
    end else begin
      unique case (state_q)
        ST_HOLD: begin
          // The count includes the current cycle, so the last hold cycle
          // is the one that sees a count of one (or zero).
          if (cnt_q <= 4'd1) begin
            state_d = ST_RUN;
            cnt_d   = '0;
          end else begin
            cnt_d = cnt_q - 4'd1;
          end
        end

        ST_RUN, ST_MEM_WAIT: begin
          fwd_active = 1'b1;
          if (!mem_ready) begin
            pipe_hold = 1'b1;
            ctrl_nop  = 1'b0;
            state_d   = ST_MEM_WAIT;
            if (state_q == ST_RUN) begin
              wait_cnt_d = 8'd1;
            end else if (wait_cnt_q != 8'hFF) begin
              wait_cnt_d = wait_cnt_q + 8'd1;
            end
            if (wait_cnt_d == TIMEOUT_VAL) begin
              timeout_d = 1'b1;
            end
          end else begin
            state_d    = ST_RUN;
            wait_cnt_d = '0;
            if (load_use) begin
              stall_evt = 1'b1;
            end else begin
              pc_enable    = 1'b1;
              if_id_enable = 1'b1;
              ctrl_nop     = 1'b0;
              if_id_flush  = branch_taken;
            end
          end
        end

        default: begin
          state_d = ST_HOLD;
        end
      endcase
    end
  end

  // State register; Reset is folded into the next-state logic above.
  always_ff @(posedge Clk) begin
    state_q    <= state_d;
    cnt_q      <= cnt_d;
    wait_cnt_q <= wait_cnt_d;
    timeout_q  <= timeout_d;
  end

  assign state       = state_q;
  assign mem_timeout = timeout_q;

  // A load in EX has no data yet, so only ALU results forward from EX.
  fwd_select u_fwd_a (
    .src(id_rn), .src_used(id_use_rn),
    .ex_rd(ex_rd), .ex_fwd_en(ex_rf_e && !ex_mem_e),
    .mem_rd(mem_rd), .mem_fwd_en(mem_rf_e),
    .wb_rd(wb_rd), .wb_fwd_en(wb_rf_e),
    .sel(raw_a)
  );

  fwd_select u_fwd_b (
    .src(id_rm), .src_used(id_use_rm),
    .ex_rd(ex_rd), .ex_fwd_en(ex_rf_e && !ex_mem_e),
    .mem_rd(mem_rd), .mem_fwd_en(mem_rf_e),
    .wb_rd(wb_rd), .wb_fwd_en(wb_rf_e),
    .sel(raw_b)
  );

  fwd_select u_fwd_c (
    .src(id_rd), .src_used(id_use_rd),
    .ex_rd(ex_rd), .ex_fwd_en(ex_rf_e && !ex_mem_e),
    .mem_rd(mem_rd), .mem_fwd_en(mem_rf_e),
    .wb_rd(wb_rd), .wb_fwd_en(wb_rf_e),
    .sel(raw_c)
  );

  // Forwarding is live in RUN and MEM_WAIT regardless of pipe_hold.
  assign fwd_a = fwd_active ? raw_a : FWD_RF;
  assign fwd_b = fwd_active ? raw_b : FWD_RF;
  assign fwd_c = fwd_active ? raw_c : FWD_RF;

`ifdef HAZARD_PERF_EN
  // Saturating event counters: bubbles, flush cycles and memory-wait cycles.
  always_ff @(posedge Clk) begin
    if (Reset) begin
      stall_count <= '0;
      flush_count <= '0;
      wait_count  <= '0;
    end else begin
      if (stall_evt && (stall_count != 16'hFFFF)) begin
        stall_count <= stall_count + 16'd1;
      end
      if (if_id_flush && (flush_count != 16'hFFFF)) begin
        flush_count <= flush_count + 16'd1;
      end
      if ((state_q == ST_MEM_WAIT) && (wait_count != 16'hFFFF)) begin
        wait_count <= wait_count + 16'd1;
      end
    end
  end
`else
  logic unused_perf;
  assign unused_perf = stall_evt;
  assign stall_count = '0;
  assign flush_count = '0;
  assign wait_count  = '0;
`endif

endmodule

// File: tb/tb_hazard_ctrl.sv
// tb_hazard_ctrl
// Scoreboard bench for hazard_ctrl: directed scenarios followed by random
// traffic. Each stimulus cycle pushes the reference model's expected outputs
// into a queue; a monitor on the falling edge pops and compares.
module tb_hazard_ctrl;

  localparam int STARTUP = 2;
  localparam int TIMEOUT = 15;

  typedef struct packed {
    logic       reset;
    logic [3:0] rn, rm, rd;
    logic       urn, urm, urd;
    logic [3:0] exRd, memRd, wbRd;
    logic       exRf, memRf, wbRf, exMem;
    logic       branch, ready;
  } stim_t;

  typedef struct packed {
    logic        pcEn, ifIdEn, nop, flush, hold;
    logic [1:0]  fa, fb, fc;
    logic        tmo;
    logic [1:0]  st;
    logic [15:0] stalls, flushes, waits;
  } exp_t;

  logic        Clk;
  logic        Reset;
  logic [3:0]  idRn, idRm, idRd;
  logic        idUseRn, idUseRm, idUseRd;
  logic [3:0]  exRd, memRd, wbRd;
  logic        exRfE, memRfE, wbRfE, exMemE;
  logic        branchTaken, memReady;
  logic        pcEnable, ifIdEnable, ctrlNop, ifIdFlush, pipeHold;
  logic [1:0]  fwdA, fwdB, fwdC;
  logic        memTimeout;
  logic [1:0]  stateOut;
  logic [15:0] stallCount, flushCount, waitCount;

  int   checks = 0;
  int   passed = 0;
  exp_t expQ[$];

  // Reference model state: phase 0 = startup hold, 1 = running, 2 = memory wait
  int mPhase    = 0;
  int mHoldLeft = (STARTUP > 1) ? STARTUP : 1;
  int mWaitLen  = 0;
  bit mTimeout  = 0;
  int mStalls   = 0;
  int mFlushes  = 0;
  int mWaits    = 0;

  hazard_ctrl #(.STARTUP_CYCLES(STARTUP), .MEM_TIMEOUT(TIMEOUT)) dut (
    .Clk(Clk), .Reset(Reset),
    .id_rn(idRn), .id_rm(idRm), .id_rd(idRd),
    .id_use_rn(idUseRn), .id_use_rm(idUseRm), .id_use_rd(idUseRd),
    .ex_rd(exRd), .mem_rd(memRd), .wb_rd(wbRd),
    .ex_rf_e(exRfE), .mem_rf_e(memRfE), .wb_rf_e(wbRfE),
    .ex_mem_e(exMemE), .branch_taken(branchTaken), .mem_ready(memReady),
    .pc_enable(pcEnable), .if_id_enable(ifIdEnable), .ctrl_nop(ctrlNop),
    .if_id_flush(ifIdFlush), .pipe_hold(pipeHold),
    .fwd_a(fwdA), .fwd_b(fwdB), .fwd_c(fwdC),
    .mem_timeout(memTimeout), .state(stateOut),
    .stall_count(stallCount), .flush_count(flushCount), .wait_count(waitCount)
  );

  initial begin
    Clk = 1'b0;
    forever #5 Clk = ~Clk;
  end

  function automatic stim_t idle();
    stim_t s;
    s = '0;
    s.ready = 1'b1;
    return s;
  endfunction

  function automatic int sat16(input int v);
    return (v > 65535) ? 65535 : v;
  endfunction

  // Youngest writer of the register wins; EX only if it is not a load.
  function automatic logic [1:0] fwdOf(input logic [3:0] src, input logic used, input stim_t s);
    if (!used || src == 4'd15) return 2'd0;
    if (s.exRf && !s.exMem && s.exRd == src) return 2'd1;
    if (s.memRf && s.memRd == src) return 2'd2;
    if (s.wbRf && s.wbRd == src) return 2'd3;
    return 2'd0;
  endfunction

  task automatic modelStep(input stim_t s, output exp_t e);
    bit loadUse;
    e       = '0;
    e.nop   = 1'b1;
    e.st    = 2'(mPhase);
    e.tmo   = mTimeout;
`ifdef HAZARD_PERF_EN
    e.stalls  = 16'(sat16(mStalls));
    e.flushes = 16'(sat16(mFlushes));
    e.waits   = 16'(sat16(mWaits));
`endif
    if (s.reset) begin
      mPhase    = 0;
      mHoldLeft = (STARTUP > 1) ? STARTUP : 1;
      mWaitLen  = 0;
      mTimeout  = 0;
      mStalls   = 0;
      mFlushes  = 0;
      mWaits    = 0;
    end else if (mPhase == 0) begin
      mHoldLeft--;
      if (mHoldLeft == 0) mPhase = 1;
    end else begin
      e.fa = fwdOf(s.rn, s.urn, s);
      e.fb = fwdOf(s.rm, s.urm, s);
      e.fc = fwdOf(s.rd, s.urd, s);
      if (mPhase == 2) mWaits++;
      if (!s.ready) begin
        e.hold   = 1'b1;
        e.nop    = 1'b0;
        mWaitLen = (mPhase == 1) ? 1 : ((mWaitLen + 1 > 255) ? 255 : mWaitLen + 1);
        mPhase   = 2;
        if (mWaitLen >= TIMEOUT) mTimeout = 1;
      end else begin
        mPhase   = 1;
        mWaitLen = 0;
        loadUse  = s.exMem && s.exRf && s.exRd != 4'd15 &&
                   ((s.urn && s.rn == s.exRd) || (s.urm && s.rm == s.exRd) ||
                    (s.urd && s.rd == s.exRd));
        if (loadUse) begin
          mStalls++;
        end else begin
          e.pcEn   = 1'b1;
          e.ifIdEn = 1'b1;
          e.nop    = 1'b0;
          if (s.branch) begin
            e.flush = 1'b1;
            mFlushes++;
          end
        end
      end
    end
  endtask

  task automatic driveInputs(input stim_t s);
    Reset = s.reset;
    idRn = s.rn; idRm = s.rm; idRd = s.rd;
    idUseRn = s.urn; idUseRm = s.urm; idUseRd = s.urd;
    exRd = s.exRd; memRd = s.memRd; wbRd = s.wbRd;
    exRfE = s.exRf; memRfE = s.memRf; wbRfE = s.wbRf; exMemE = s.exMem;
    branchTaken = s.branch; memReady = s.ready;
  endtask

  task automatic applyStimulus(input stim_t s);
    exp_t e;
    @(posedge Clk);
    #1;
    driveInputs(s);
    modelStep(s, e);
    expQ.push_back(e);
  endtask

  task automatic cmp(input string name, input logic [15:0] act, input logic [15:0] want);
    checks++;
    if (act === want) passed++;
    else $display("[TB] FAIL %s at %0t: got %0h expected %0h", name, $time, act, want);
  endtask

  task automatic checkOutput(input exp_t e);
    cmp("pc_enable",    16'(pcEnable),   16'(e.pcEn));
    cmp("if_id_enable", 16'(ifIdEnable), 16'(e.ifIdEn));
    cmp("ctrl_nop",     16'(ctrlNop),    16'(e.nop));
    cmp("if_id_flush",  16'(ifIdFlush),  16'(e.flush));
    cmp("pipe_hold",    16'(pipeHold),   16'(e.hold));
    cmp("fwd_a",        16'(fwdA),       16'(e.fa));
    cmp("fwd_b",        16'(fwdB),       16'(e.fb));
    cmp("fwd_c",        16'(fwdC),       16'(e.fc));
    cmp("mem_timeout",  16'(memTimeout), 16'(e.tmo));
    cmp("state",        16'(stateOut),   16'(e.st));
    cmp("stall_count",  stallCount,      e.stalls);
    cmp("flush_count",  flushCount,      e.flushes);
    cmp("wait_count",   waitCount,       e.waits);
  endtask

  // Monitor: every cycle the DUT presents a full set of outputs.
  initial begin
    forever begin
      @(negedge Clk);
      if (expQ.size() > 0) checkOutput(expQ.pop_front());
    end
  end

  function automatic logic [3:0] pickReg();
    int r;
    r = $urandom_range(0, 5);
    return (r == 5) ? 4'd15 : 4'(r);
  endfunction

  initial begin
    stim_t s;
    s = idle();
    s.reset = 1'b1;
    driveInputs(s);

    // Startup hold after a two-cycle reset
    applyStimulus(s);
    applyStimulus(s);
    s = idle();
    repeat (4) applyStimulus(s);

    // Load-use bubble, then the load forwards from MEM
    s = idle(); s.exMem = 1; s.exRf = 1; s.exRd = 4'd3; s.rn = 4'd3; s.urn = 1;
    applyStimulus(s);
    s = idle(); s.memRd = 4'd3; s.memRf = 1; s.rn = 4'd3; s.urn = 1;
    applyStimulus(s);

    // EX beats MEM; R15 never forwards
    s = idle(); s.exRd = 4'd5; s.exRf = 1; s.memRd = 4'd5; s.memRf = 1; s.rm = 4'd5; s.urm = 1;
    applyStimulus(s);
    s.rm = 4'd15;
    applyStimulus(s);
    s.exRd = 4'd15; s.memRd = 4'd15;
    applyStimulus(s);

    // Branch alone, then branch under a load-use stall
    s = idle(); s.branch = 1;
    applyStimulus(s);
    s = idle(); s.branch = 1; s.exMem = 1; s.exRf = 1; s.exRd = 4'd3; s.rn = 4'd3; s.urn = 1;
    applyStimulus(s);

    // Long memory wait crossing the timeout, then release
    s = idle(); s.ready = 0; s.wbRf = 1; s.wbRd = 4'd2; s.rd = 4'd2; s.urd = 1;
    repeat (20) applyStimulus(s);
    s.ready = 1;
    applyStimulus(s);
    s = idle();
    applyStimulus(s);

    // Reset in the middle of a memory wait
    s = idle(); s.ready = 0;
    repeat (5) applyStimulus(s);
    s.reset = 1;
    applyStimulus(s);
    s = idle();
    repeat (4) applyStimulus(s);

    // Random traffic
    for (int i = 0; i < 600; i++) begin
      s.reset  = ($urandom_range(0, 149) == 0);
      s.rn     = pickReg(); s.rm = pickReg(); s.rd = pickReg();
      s.urn    = 1'($urandom_range(0, 1));
      s.urm    = 1'($urandom_range(0, 1));
      s.urd    = 1'($urandom_range(0, 1));
      s.exRd   = pickReg(); s.memRd = pickReg(); s.wbRd = pickReg();
      s.exRf   = 1'($urandom_range(0, 1));
      s.memRf  = 1'($urandom_range(0, 1));
      s.wbRf   = 1'($urandom_range(0, 1));
      s.exMem  = 1'($urandom_range(0, 1));
      s.branch = ($urandom_range(0, 3) == 0);
      s.ready  = ($urandom_range(0, 5) != 0);
      applyStimulus(s);
    end

    repeat (3) @(negedge Clk);
    cmp("queue_drained", 16'(expQ.size()), 16'd0);
    $display("%0d/%0d checks passed", passed, checks);
    $finish;
  end

endmodule
